mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mux_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Four-requester burst arbiter feeding one registered 16-bit output stage.
// A two-state FSM (ARB / GRANT) picks one requester, holds the grant for a
// burst, then returns to ARB for at least one cycle before the next decision.
// A burst ends on the beat carrying in_last, or on the beat that brings the
// beat count to BURST_MAX, whichever comes first.
//
// Arbitration is round-robin by default: the search starts at rr_ptr and
// wraps upward, and rr_ptr moves to (select+1) when a burst ends.
// Define MUX_ARBITER_FIXED_PRIO_EN to build a fixed-priority arbiter instead
// (requester 0 highest, requester 3 lowest). In that build there is no rr_ptr.
//
// Parameters
//   BURST_MAX  maximum beats per grant (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-requester data valid (bit i = requester i)
//   in_last    per-requester last beat of burst
//   input_1..4 requester 0..3 data
//   in_ready   per-requester accept (only the granted bit can be high)
//   out_data   registered output data
//   out_valid  out_data holds a beat
//   out_ready  downstream accept
//   select     index of the granted requester (holds its value in ARB)
//   grant      one-hot grant, zero when no grant is held
//   busy       high while in GRANT
// -----------------------------------------------------------------------------
module mux_arbiter #(
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_valid,
  input  logic [3:0]  in_last,
  input  logic [15:0] input_1,
  input  logic [15:0] input_2,
  input  logic [15:0] input_3,
  input  logic [15:0] input_4,
  output logic [3:0]  in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  select,
  output logic [3:0]  grant,
  output logic        busy
);

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_beat_cnt;
  logic [1:0]  r_select;
  logic [3:0]  r_grant;
  logic [15:0] r_out_data;
  logic        r_out_valid;
`ifndef MUX_ARBITER_FIXED_PRIO_EN
  logic [1:0]  r_rr_ptr;
  logic [1:0]  w_cand;
`endif

  logic [1:0]  w_win;
  logic        w_any;
  logic [15:0] w_sel_data;
  logic        w_can_accept;
  logic        w_xfer;
  logic        w_burst_end;

  // The output register can take a new beat when it is empty or being drained
  // on this same edge.
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_xfer       = (r_state == GRANT) && in_valid[r_select] && w_can_accept;
  assign w_burst_end  = w_xfer &&
                        (in_last[r_select] ||
                         (({1'b0, r_beat_cnt} + 9'd1) == 9'(BURST_MAX)));
  assign w_any        = |in_valid;

  always_comb begin
    in_ready = 4'b0000;
    if (r_state == GRANT) begin
      in_ready[r_select] = w_can_accept;
    end
  end

  always_comb begin
    case (r_select)
      2'd0:    w_sel_data = input_1;
      2'd1:    w_sel_data = input_2;
      2'd2:    w_sel_data = input_3;
      default: w_sel_data = input_4;
    endcase
  end

  // Winner selection. Scanning from the far end down means the candidate
  // closest to the start point is the last assignment and therefore wins.
`ifdef MUX_ARBITER_FIXED_PRIO_EN
  always_comb begin
    w_win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[k]) w_win = 2'(k);
    end
  end
`else
  always_comb begin
    w_win  = 2'd0;
    w_cand = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_rr_ptr + 2'(k);
      if (in_valid[w_cand]) w_win = w_cand;
    end
  end
`endif

  // Arbitration FSM with registered select/grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_beat_cnt <= 8'd0;
      r_select   <= 2'd0;
      r_grant    <= 4'b0000;
`ifndef MUX_ARBITER_FIXED_PRIO_EN
      r_rr_ptr   <= 2'd0;
`endif
    end else begin
      case (r_state)
        ARB: begin
          if (w_any) begin
            r_select   <= w_win;
            r_grant    <= 4'(1) << w_win;
            r_beat_cnt <= 8'd0;
            r_state    <= GRANT;
          end else begin
            r_grant <= 4'b0000;
          end
        end
        GRANT: begin
          // A dropped in_valid simply stalls here: no timeout by design.
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_burst_end) begin
              r_state <= ARB;
              r_grant <= 4'b0000;
`ifndef MUX_ARBITER_FIXED_PRIO_EN
              r_rr_ptr <= r_select + 2'd1;
`endif
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // Output stage: drains on out_ready independently of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign select    = r_select;
  assign grant     = r_grant;
  assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
//
// Scoreboard bench for mux_arbiter (BURST_MAX = 3). Stimulus pushes the
// hand-computed output beats and grant sequence into queues; two monitors pop
// and compare whenever the DUT hands over a beat or raises a new grant.
// Requesters are modelled as simple beat sources that advance on handshake.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [15:0] input_1, input_2, input_3, input_4;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  select;
  logic [3:0]  grant;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_data[$];
  logic [3:0]  exp_grant[$];

  int         n_beats[4];
  int         sent[4];
  int         gap_at[4];
  int         gap_left[4];
  logic [7:0] last_mask[4];
  bit         toggle_ready;
  logic [3:0] last_hs;
  logic [3:0] prev_grant;

  mux_arbiter #(.BURST_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .input_1   (input_1),
    .input_2   (input_2),
    .input_3   (input_3),
    .input_4   (input_4),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .select    (select),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] tag(input int i, input int b);
    return 16'hA000 + 16'(i) + 16'(b << 8);
  endfunction

  task automatic drive_inputs();
    logic [15:0] d[4];
    logic        v;
    for (int i = 0; i < 4; i++) begin
      v = (sent[i] < n_beats[i]) && !(sent[i] == gap_at[i] && gap_left[i] > 0);
      in_valid[i] = v;
      in_last[i]  = v && (sent[i] < 8) && last_mask[i][sent[i]];
      d[i]        = v ? tag(i, sent[i]) : 16'hDEAD;
    end
    input_1 = d[0];
    input_2 = d[1];
    input_3 = d[2];
    input_4 = d[3];
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) begin
      n_beats[i]   = 0;
      sent[i]      = 0;
      gap_at[i]    = -1;
      gap_left[i]  = 0;
      last_mask[i] = 8'h00;
    end
  endtask

  // One clock: sample the handshake mid-cycle, then advance the requesters.
  task automatic step();
    @(negedge clk);
    last_hs = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (sent[i] == gap_at[i] && gap_left[i] > 0) gap_left[i]--;
      if (last_hs[i]) sent[i]++;
    end
    if (toggle_ready) out_ready = ~out_ready;
    drive_inputs();
  endtask

  task automatic wait_idle(input string name);
    int  k;
    bit  done;
    k    = 0;
    done = 1'b0;
    while (k < 200 && !done) begin
      step();
      k++;
      done = (grant == 4'b0000) && !out_valid && (exp_data.size() == 0);
      for (int i = 0; i < 4; i++) if (sent[i] < n_beats[i]) done = 1'b0;
    end
    check({name, "_complete"}, 32'(done), 32'd1);
    repeat (3) step();
    check({name, "_data_left"}, 32'(exp_data.size()), 32'd0);
    check({name, "_grant_left"}, 32'(exp_grant.size()), 32'd0);
  endtask

  // Data monitor: a beat leaves on the coming edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_data_extra: got %0h required no beat", out_data);
      end else begin
        check("out_data", out_data, exp_data.pop_front());
      end
    end
  end

  // Grant monitor: sequence of new grants plus per-cycle consistency.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant <= 4'b0000;
    end else begin
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (exp_grant.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL grant_extra: got %0h required no grant", grant);
        end else begin
          check("grant_seq", grant, exp_grant.pop_front());
        end
      end
      if (prev_grant != 4'b0000)
        check("grant_hold", 32'(grant == prev_grant || grant == 4'b0000), 32'd1);
      if (grant != 4'b0000) begin
        check("grant_select", grant, 4'(1) << select);
        check("busy_grant", busy, 1'b1);
        check("ready_subset", in_ready & ~grant, 4'b0000);
      end else begin
        check("busy_idle", busy, 1'b0);
        check("ready_idle", in_ready, 4'b0000);
      end
      prev_grant <= grant;
    end
  end

  initial begin
    rst_n        = 1'b0;
    out_ready    = 1'b1;
    toggle_ready = 1'b0;
    last_hs      = 4'b0000;
    clear_plan();

    // ---- reset, then first arbitration ----
`ifdef MUX_ARBITER_FIXED_PRIO_EN
    n_beats[0] = 4; last_mask[0] = 8'b1010;
    n_beats[3] = 2; last_mask[3] = 8'b0010;
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b1000);
    exp_data.push_back(16'hA000); exp_data.push_back(16'hA100);
    exp_data.push_back(16'hA200); exp_data.push_back(16'hA300);
    exp_data.push_back(16'hA003); exp_data.push_back(16'hA103);
`else
    n_beats[0] = 4; last_mask[0] = 8'b1010;
    for (int i = 1; i < 4; i++) begin
      n_beats[i]   = 2;
      last_mask[i] = 8'b0010;
    end
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    exp_data.push_back(16'hA000); exp_data.push_back(16'hA100);
    exp_data.push_back(16'hA001); exp_data.push_back(16'hA101);
    exp_data.push_back(16'hA002); exp_data.push_back(16'hA102);
    exp_data.push_back(16'hA003); exp_data.push_back(16'hA103);
    exp_data.push_back(16'hA200); exp_data.push_back(16'hA300);
`endif
    drive_inputs();
    repeat (3) step();
    check("rst_grant", grant, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_select", select, 2'b00);
    rst_n = 1'b1;
    check("release_grant_0", grant, 4'b0000);
    step();
    check("release_grant_1", grant, 4'b0001);
    step();
    check("release_grant_2", grant, 4'b0001);
    wait_idle("first_bursts");

`ifndef MUX_ARBITER_FIXED_PRIO_EN
    // ---- burst cap with out_ready toggling ----
    clear_plan();
    n_beats[2] = 6;
    n_beats[3] = 1; last_mask[3] = 8'b0001;
    toggle_ready = 1'b1;
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0100);
    exp_data.push_back(16'hA002); exp_data.push_back(16'hA102);
    exp_data.push_back(16'hA202); exp_data.push_back(16'hA003);
    exp_data.push_back(16'hA302); exp_data.push_back(16'hA402);
    exp_data.push_back(16'hA502);
    drive_inputs();
    wait_idle("burst_cap");
    toggle_ready = 1'b0;
    out_ready    = 1'b1;

    // ---- requester 1 drops valid for 5 cycles mid-burst ----
    clear_plan();
    n_beats[1] = 4; last_mask[1] = 8'b1000;
    gap_at[1]  = 2; gap_left[1]  = 5;
    exp_grant.push_back(4'b0010); exp_grant.push_back(4'b0010);
    exp_data.push_back(16'hA001); exp_data.push_back(16'hA101);
    exp_data.push_back(16'hA201); exp_data.push_back(16'hA301);
    drive_inputs();
    begin
      int k;
      k = 0;
      while (sent[1] < 2 && k < 20) begin
        step();
        k++;
      end
      check("gap_reached", 32'(sent[1]), 32'd2);
      for (int g = 0; g < 5; g++) begin
        step();
        check("gap_grant", grant, 4'b0010);
        check("gap_no_xfer", last_hs, 4'b0000);
      end
    end
    wait_idle("valid_drop");

    // ---- reset while an output beat is pending ----
    clear_plan();
    n_beats[3] = 3;
    out_ready  = 1'b0;
    exp_grant.push_back(4'b1000);
    drive_inputs();
    begin
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
        step();
        k++;
      end
    end
    check("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 16'h0000);
    check("midrst_grant", grant, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 4'b0000);
    check("midrst_select", select, 2'b00);
    exp_data.delete();
    clear_plan();
    n_beats[0] = 2; last_mask[0] = 8'b0010;
    n_beats[3] = 1; last_mask[3] = 8'b0001;
    out_ready  = 1'b1;
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b1000);
    exp_data.push_back(16'hA000); exp_data.push_back(16'hA100);
    exp_data.push_back(16'hA003);
    drive_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    wait_idle("after_reset");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
